// File: rtl/sram_arb_if.sv
// sram_arb_if: request/response and SRAM pin bundle shared by sram_arb_ctrl and its requesters.
//   slave  : controller view (takes requests, returns responses, drives the macro pins)
//   master : requester/macro view (drives requests, consumes responses, returns sram_q)
interface sram_arb_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
);
    logic                  req0_valid, req0_ready, req0_wen;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req1_valid, req1_ready, req1_wen;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  rsp0_valid, rsp0_ready;
    logic [DATA_WIDTH-1:0] rsp0_data;
    logic                  rsp1_valid, rsp1_ready;
    logic [DATA_WIDTH-1:0] rsp1_data;
    logic                  sram_ceb, sram_web;
    logic [ADDR_WIDTH-1:0] sram_a;
    logic [DATA_WIDTH-1:0] sram_d, sram_q;
    logic [1:0]            sram_rtsel, sram_wtsel;

    modport slave (
        input  req0_valid, req0_wen, req0_addr, req0_wdata,
        input  req1_valid, req1_wen, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  rsp0_ready, rsp1_ready,
        output sram_ceb, sram_web, sram_a, sram_d, sram_rtsel, sram_wtsel,
        input  sram_q
    );

    modport master (
        output req0_valid, req0_wen, req0_addr, req0_wdata,
        output req1_valid, req1_wen, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output rsp0_ready, rsp1_ready,
        input  sram_ceb, sram_web, sram_a, sram_d, sram_rtsel, sram_wtsel,
        output sram_q
    );
endinterface

// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: two-port arbiter/controller for one single-port SRAM macro with per-port read response FIFOs.
//   clk_i    : clock for all state and the macro
//   reset_i  : asynchronous active-high reset
//   bus      : sram_arb_if.slave (req0/req1 handshakes, rsp0/rsp1 FIFOs, registered macro pins, sram_q)
//   perf_*_o : grant/conflict counters, present only when SRAM_ARB_PERF_EN is defined
module sram_arb_ctrl #(
    parameter int         DATA_WIDTH    = 16,
    parameter int         ADDR_WIDTH    = 9,
    parameter int         RSP_DEPTH     = 3,
    parameter int         PRIORITY_MODE = 0,
    parameter logic [1:0] TSEL          = 2'b00
) (
    input  logic        clk_i,
    input  logic        reset_i,
`ifdef SRAM_ARB_PERF_EN
    output logic [15:0] perf_grant0_o,
    output logic [15:0] perf_grant1_o,
    output logic [15:0] perf_conflict_o,
`endif
    sram_arb_if.slave   bus
);
    localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [1:0]            valid, wen, rready, elig, grant, push, pop, rvalid;
    logic [ADDR_WIDTH-1:0] addr [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [DATA_WIDTH-1:0] rdata [2];
    logic                  pick1, sel_wen;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sram_ceb_q, sram_web_q;
    logic [ADDR_WIDTH-1:0] sram_a_q;
    logic [DATA_WIDTH-1:0] sram_d_q;
    logic                  rd1_v_q, rd1_p_q, rd2_v_q, rd2_p_q, last_q;

    assign valid    = {bus.req1_valid, bus.req0_valid};
    assign wen      = {bus.req1_wen, bus.req0_wen};
    assign rready   = {bus.rsp1_ready, bus.rsp0_ready};
    assign addr[0]  = bus.req0_addr;
    assign addr[1]  = bus.req1_addr;
    assign wdata[0] = bus.req0_wdata;
    assign wdata[1] = bus.req1_wdata;

    // Port 1 wins only if port 0 is not eligible, or on a round-robin tie when port 0 was granted last.
    always_comb begin
        pick1 = elig[1] & (~elig[0] | (PRIORITY_MODE == 0 && !last_q));
        grant = {pick1, elig[0] & ~pick1};
    end

    assign sel_wen   = grant[1] ? wen[1] : wen[0];
    assign sel_addr  = grant[1] ? addr[1] : addr[0];
    assign sel_wdata = grant[1] ? wdata[1] : wdata[0];

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.sram_ceb   = sram_ceb_q;
    assign bus.sram_web   = sram_web_q;
    assign bus.sram_a     = sram_a_q;
    assign bus.sram_d     = sram_d_q;
    assign bus.sram_rtsel = TSEL;
    assign bus.sram_wtsel = TSEL;
    assign bus.rsp0_valid = rvalid[0];
    assign bus.rsp1_valid = rvalid[1];
    assign bus.rsp0_data  = rdata[0];
    assign bus.rsp1_data  = rdata[1];

    // Macro pins are registered; address/data hold when idle so the macro inputs do not toggle.
    // The two-stage tag follows each read so sram_q lands in the right FIFO the cycle it is valid.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sram_ceb_q <= 1'b1;
            sram_web_q <= 1'b1;
            sram_a_q   <= '0;
            sram_d_q   <= '0;
            rd1_v_q    <= 1'b0;
            rd1_p_q    <= 1'b0;
            rd2_v_q    <= 1'b0;
            rd2_p_q    <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            sram_ceb_q <= ~|grant;
            sram_web_q <= ~(|grant & sel_wen);
            if (|grant) begin
                sram_a_q <= sel_addr;
                last_q   <= grant[1];
            end
            if (|grant & sel_wen) sram_d_q <= sel_wdata;
            rd1_v_q <= |grant & ~sel_wen;
            rd1_p_q <= grant[1];
            rd2_v_q <= rd1_v_q;
            rd2_p_q <= rd1_p_q;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
        logic [PW-1:0]         wp_q, rp_q;
        logic [CW-1:0]         cnt_q, cred_q;
        assign elig[p]   = valid[p] & (wen[p] | (cred_q != '0));
        assign rvalid[p] = cnt_q != '0;
        assign pop[p]    = rvalid[p] & rready[p];
        assign push[p]   = rd2_v_q & (rd2_p_q == 1'(p));
        assign rdata[p]  = mem[rp_q];
        // A credit is held from read acceptance until its response is popped, bounding FIFO occupancy.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                wp_q   <= '0;
                rp_q   <= '0;
                cnt_q  <= '0;
                cred_q <= CW'(RSP_DEPTH);
            end else begin
                if (push[p]) wp_q <= (wp_q == PW'(RSP_DEPTH - 1)) ? '0 : wp_q + PW'(1);
                if (pop[p]) rp_q <= (rp_q == PW'(RSP_DEPTH - 1)) ? '0 : rp_q + PW'(1);
                cnt_q  <= cnt_q + CW'(push[p]) - CW'(pop[p]);
                cred_q <= cred_q - CW'(grant[p] & ~wen[p]) + CW'(pop[p]);
            end
        end
        always_ff @(posedge clk_i) begin
            if (push[p]) mem[wp_q] <= bus.sram_q;
        end
    end

`ifdef SRAM_ARB_PERF_EN
    logic [15:0] perf_g0_q, perf_g1_q, perf_cf_q;
    // With both ports valid at most one is granted, so every such cycle stalls one port.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            perf_g0_q <= '0;
            perf_g1_q <= '0;
            perf_cf_q <= '0;
        end else begin
            if (grant[0] && perf_g0_q != 16'hFFFF) perf_g0_q <= perf_g0_q + 16'd1;
            if (grant[1] && perf_g1_q != 16'hFFFF) perf_g1_q <= perf_g1_q + 16'd1;
            if (&valid && perf_cf_q != 16'hFFFF) perf_cf_q <= perf_cf_q + 16'd1;
        end
    end
    assign perf_grant0_o   = perf_g0_q;
    assign perf_grant1_o   = perf_g1_q;
    assign perf_conflict_o = perf_cf_q;
`else
`endif
endmodule

// File: tb/tb_sram_arb_ctrl.sv
// tb_sram_arb_ctrl: self-checking bench for sram_arb_ctrl (round-robin and fixed-priority instances).
module tb_sram_arb_ctrl;
    logic clk;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sram_arb_if #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) b0 ();
    sram_arb_if #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) b1 ();

`ifdef SRAM_ARB_PERF_EN
    logic [15:0] pg0, pg1, pcf, xg0, xg1, xcf;
`endif

    sram_arb_ctrl #(.PRIORITY_MODE(0)) dut_rr (
        .clk_i(clk), .reset_i(reset),
`ifdef SRAM_ARB_PERF_EN
        .perf_grant0_o(pg0), .perf_grant1_o(pg1), .perf_conflict_o(pcf),
`endif
        .bus(b0.slave)
    );

    sram_arb_ctrl #(.PRIORITY_MODE(1)) dut_fp (
        .clk_i(clk), .reset_i(reset),
`ifdef SRAM_ARB_PERF_EN
        .perf_grant0_o(xg0), .perf_grant1_o(xg1), .perf_conflict_o(xcf),
`endif
        .bus(b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 37 + 'h0C00);
    endfunction

    // Behavioural macro models: write or read on rising edge when selected, Q one cycle later.
    logic [15:0] m0 [512];
    logic [15:0] m1 [512];
    bit          w0 [512];
    bit          w1 [512];
    always @(posedge clk) begin
        if (!b0.sram_ceb) begin
            if (!b0.sram_web) begin
                m0[b0.sram_a] <= b0.sram_d;
                w0[b0.sram_a] <= 1'b1;
            end else b0.sram_q <= w0[b0.sram_a] ? m0[b0.sram_a] : init_val(int'(b0.sram_a));
        end
        if (!b1.sram_ceb) begin
            if (!b1.sram_web) begin
                m1[b1.sram_a] <= b1.sram_d;
                w1[b1.sram_a] <= 1'b1;
            end else b1.sram_q <= w1[b1.sram_a] ? m1[b1.sram_a] : init_val(int'(b1.sram_a));
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard for the round-robin instance: reference memory updated in grant order,
    // expected read data queued at acceptance and compared at pop.
    logic [15:0] ref_mem [512];
    bit          ref_wr [512];
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    function automatic logic [15:0] ref_rd(input logic [8:0] a);
        return ref_wr[a] ? ref_mem[a] : init_val(int'(a));
    endfunction

    always @(posedge reset) begin
        q0.delete();
        q1.delete();
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (b0.req0_valid && b0.req0_ready) begin
                if (b0.req0_wen) begin
                    ref_mem[b0.req0_addr] = b0.req0_wdata;
                    ref_wr[b0.req0_addr]  = 1'b1;
                end else q0.push_back(ref_rd(b0.req0_addr));
            end
            if (b0.req1_valid && b0.req1_ready) begin
                if (b0.req1_wen) begin
                    ref_mem[b0.req1_addr] = b0.req1_wdata;
                    ref_wr[b0.req1_addr]  = 1'b1;
                end else q1.push_back(ref_rd(b0.req1_addr));
            end
            if (b0.rsp0_valid && b0.rsp0_ready) begin
                chk("sb0_pending", q0.size() != 0, 1);
                if (q0.size() != 0) chk("sb0_data", b0.rsp0_data, q0.pop_front());
            end
            if (b0.rsp1_valid && b0.rsp1_ready) begin
                chk("sb1_pending", q1.size() != 0, 1);
                if (q1.size() != 0) chk("sb1_data", b0.rsp1_data, q1.pop_front());
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drv0(input logic v, input logic w, input logic [8:0] a, input logic [15:0] d);
        b0.req0_valid = v; b0.req0_wen = w; b0.req0_addr = a; b0.req0_wdata = d;
    endtask

    task automatic drv1(input logic v, input logic w, input logic [8:0] a, input logic [15:0] d);
        b0.req1_valid = v; b0.req1_wen = w; b0.req1_addr = a; b0.req1_wdata = d;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (q0.size() + q1.size()) > 0; k++) begin
            smp();
            nxt();
        end
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
    endtask

    typedef struct {
        logic        v0, w0;
        logic [8:0]  a0;
        logic [15:0] d0;
        logic        v1, w1;
        logic [8:0]  a1;
        logic [15:0] d1;
        logic        r0, r1;
    } vec_t;

    function automatic vec_t mk(input bit v0, input bit wr0, input int a0, input int d0,
                                input bit v1, input bit wr1, input int a1, input int d1,
                                input bit r0, input bit r1);
        vec_t t;
        t.v0 = v0; t.w0 = wr0; t.a0 = 9'(a0); t.d0 = 16'(d0);
        t.v1 = v1; t.w1 = wr1; t.a1 = 9'(a1); t.d1 = 16'(d1);
        t.r0 = r0; t.r1 = r1;
        return t;
    endfunction

    vec_t tv [14];

    task automatic chk_issue(input int j);
        logic g;
        g = tv[j].r0 | tv[j].r1;
        chk($sformatf("tv%0d_ceb", j), b0.sram_ceb, !g);
        chk($sformatf("tv%0d_web", j), b0.sram_web, tv[j].r0 ? !tv[j].w0 : tv[j].r1 ? !tv[j].w1 : 1'b1);
        if (g) chk($sformatf("tv%0d_a", j), b0.sram_a, tv[j].r0 ? tv[j].a0 : tv[j].a1);
    endtask

    int  acc;
    bit  got;

    initial begin
        tv[0]  = mk(1, 1, 'h011, 'hBEEF, 0, 0, 0,     0,      1, 0);
        tv[1]  = mk(1, 0, 'h011, 0,      0, 0, 0,     0,      1, 0);
        tv[2]  = mk(0, 0, 0,     0,      0, 0, 0,     0,      0, 0);
        tv[3]  = mk(0, 0, 0,     0,      1, 1, 'h020, 'h5A5A, 0, 1);
        tv[4]  = mk(1, 0, 'h010, 0,      1, 0, 'h020, 0,      1, 0);
        tv[5]  = mk(1, 0, 'h011, 0,      1, 0, 'h020, 0,      0, 1);
        tv[6]  = mk(1, 0, 'h020, 0,      1, 0, 'h010, 0,      1, 0);
        tv[7]  = mk(1, 0, 'h011, 0,      1, 0, 'h011, 0,      0, 1);
        tv[8]  = mk(1, 1, 'h030, 'h1111, 1, 0, 'h030, 0,      1, 0);
        tv[9]  = mk(0, 0, 0,     0,      1, 0, 'h030, 0,      0, 1);
        tv[10] = mk(1, 0, 'h030, 0,      1, 1, 'h030, 'h2222, 1, 0);
        tv[11] = mk(0, 0, 0,     0,      1, 1, 'h030, 'h2222, 0, 1);
        tv[12] = mk(1, 0, 'h030, 0,      1, 0, 'h030, 0,      1, 0);
        tv[13] = mk(0, 0, 0,     0,      1, 0, 'h1FE, 0,      0, 1);

        drv0(0, 0, 0, 0);
        drv1(0, 0, 0, 0);
        b0.rsp0_ready = 1'b1; b0.rsp1_ready = 1'b1;
        b1.req0_valid = 0; b1.req0_wen = 0; b1.req0_addr = 0; b1.req0_wdata = 0;
        b1.req1_valid = 0; b1.req1_wen = 0; b1.req1_addr = 0; b1.req1_wdata = 0;
        b1.rsp0_ready = 1'b1; b1.rsp1_ready = 1'b1;

        // Reset state
        smp();
        chk("rst_ceb", b0.sram_ceb, 1);
        chk("rst_web", b0.sram_web, 1);
        chk("rst_a", b0.sram_a, 0);
        chk("rst_d", b0.sram_d, 0);
        chk("rst_rsp0", b0.rsp0_valid, 0);
        chk("rst_rsp1", b0.rsp1_valid, 0);
        chk("rst_tsel", {b0.sram_rtsel, b0.sram_wtsel}, 0);
        nxt();
        reset = 1'b0;

        // Write then read-back with exact issue timing and 2-cycle latency
        b0.rsp0_ready = 1'b0;
        drv0(1, 1, 9'h010, 16'hA5A5);
        smp(); chk("a_wr_rdy", b0.req0_ready, 1);
        nxt(); drv0(1, 0, 9'h010, 0);
        smp();
        chk("a_wr_ceb", b0.sram_ceb, 0);
        chk("a_wr_web", b0.sram_web, 0);
        chk("a_wr_a", b0.sram_a, 9'h010);
        chk("a_wr_d", b0.sram_d, 16'hA5A5);
        chk("a_rd_rdy", b0.req0_ready, 1);
        nxt(); drv0(0, 0, 0, 0);
        smp();
        chk("a_rd_ceb", b0.sram_ceb, 0);
        chk("a_rd_web", b0.sram_web, 1);
        chk("a_rd_dhold", b0.sram_d, 16'hA5A5);
        chk("a_lat1", b0.rsp0_valid, 0);
        nxt(); smp();
        chk("a_lat2", b0.rsp0_valid, 0);
        chk("a_idle_ceb", b0.sram_ceb, 1);
        chk("a_idle_ahold", b0.sram_a, 9'h010);
        nxt(); smp();
        chk("a_lat3", b0.rsp0_valid, 1);
        chk("a_data", b0.rsp0_data, 16'hA5A5);
        nxt(); smp();
        chk("a_hold_v", b0.rsp0_valid, 1);
        chk("a_hold_d", b0.rsp0_data, 16'hA5A5);
        nxt(); b0.rsp0_ready = 1'b1;
        smp(); nxt(); smp();
        chk("a_popped", b0.rsp0_valid, 0);
        nxt();

        // Table-driven arbitration vectors
        for (int i = 0; i < 14; i++) begin
            drv0(tv[i].v0, tv[i].w0, tv[i].a0, tv[i].d0);
            drv1(tv[i].v1, tv[i].w1, tv[i].a1, tv[i].d1);
            smp();
            chk($sformatf("tv%0d_rdy0", i), b0.req0_ready, tv[i].r0);
            chk($sformatf("tv%0d_rdy1", i), b0.req1_ready, tv[i].r1);
            if (i > 0) chk_issue(i - 1);
            nxt();
        end
        drv0(0, 0, 0, 0);
        drv1(0, 0, 0, 0);
        smp(); chk_issue(13); nxt();
        drain();

        // Credit exhaustion on port 1; port 0 keeps flowing
        b0.rsp1_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            drv1(1, 0, 9'(9'h040 + acc), 0);
            smp();
            if (b0.req1_ready) acc++;
            nxt();
        end
        chk("b_acc3", acc, 3);
        chk("b_fifo_full", b0.rsp1_valid, 1);
        for (int k = 0; k < 3; k++) begin
            drv0(1, 0, 9'(9'h050 + k), 0);
            smp();
            chk("b_p0_go", b0.req0_ready, 1);
            chk("b_p1_blk", b0.req1_ready, 0);
            nxt();
        end
        drv0(0, 0, 0, 0);
        b0.rsp1_ready = 1'b1;
        for (int k = 0; k < 12 && acc < 4; k++) begin
            drv1(1, 0, 9'(9'h040 + acc), 0);
            smp();
            if (b0.req1_ready) acc++;
            nxt();
        end
        drv1(0, 0, 0, 0);
        chk("b_acc4", acc, 4);
        drain();

        // Same-cycle write/read to 0x1FF, fixed priority: write first
        b1.req0_valid = 1; b1.req0_wen = 1; b1.req0_addr = 9'h1FF; b1.req0_wdata = 16'h1234;
        b1.req1_valid = 1; b1.req1_wen = 0; b1.req1_addr = 9'h1FF;
        smp();
        chk("c1_rdy0", b1.req0_ready, 1);
        chk("c1_rdy1", b1.req1_ready, 0);
        nxt(); b1.req0_valid = 0;
        smp(); chk("c1_rd_go", b1.req1_ready, 1);
        nxt(); b1.req1_valid = 0;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            smp();
            if (b1.rsp1_valid) begin got = 1; break; end
            nxt();
        end
        chk("c1_rsp_v", got, 1);
        chk("c1_rsp_d", b1.rsp1_data, 16'h1234);
        nxt();

        // Same pattern, round robin with pointer favouring port 1: read sees old value
        drv0(1, 0, 9'h100, 0);
        smp(); chk("c0_pre", b0.req0_ready, 1);
        nxt();
        drv0(1, 1, 9'h1FF, 16'h1234);
        drv1(1, 0, 9'h1FF, 0);
        smp();
        chk("c0_rdy1", b0.req1_ready, 1);
        chk("c0_rdy0", b0.req0_ready, 0);
        nxt(); drv1(0, 0, 0, 0);
        smp(); chk("c0_wr_go", b0.req0_ready, 1);
        nxt(); drv0(0, 0, 0, 0);
        got = 0;
        for (int k = 0; k < 10; k++) begin
            smp();
            if (b0.rsp1_valid) begin got = 1; break; end
            nxt();
        end
        chk("c0_rsp_v", got, 1);
        chk("c0_rsp_old", b0.rsp1_data, init_val('h1FF));
        nxt();
        drain();

        // Reset one cycle after a read acceptance
        drv0(1, 0, 9'h060, 0);
        smp(); chk("d_rdy", b0.req0_ready, 1);
        nxt(); drv0(0, 0, 0, 0);
        reset = 1'b1;
        #1 chk("d_ceb_async", b0.sram_ceb, 1);
        smp(); nxt();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("d_no_rsp", b0.rsp0_valid, 0);
            nxt();
        end
        b0.rsp0_ready = 1'b0;
        acc = 0;
        drv0(1, 0, 9'h060, 0);
        drv1(1, 0, 9'h061, 0);
        smp();
        chk("d_tie_p0", b0.req0_ready, 1);
        chk("d_tie_p1", b0.req1_ready, 0);
        if (b0.req0_ready) acc++;
        nxt(); drv1(0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            drv0(1, 0, 9'(9'h060 + acc), 0);
            smp();
            if (b0.req0_ready) acc++;
            nxt();
        end
        drv0(0, 0, 0, 0);
        chk("d_cred3", acc, 3);
        b0.rsp0_ready = 1'b1;
        drain();

`ifdef SRAM_ARB_PERF_EN
        reset = 1'b1;
        smp(); nxt();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drv0(1, 0, 9'(9'h070 + k), 0);
            drv1(1, 0, 9'(9'h080 + k), 0);
            smp(); nxt();
        end
        drv0(0, 0, 0, 0);
        drv1(0, 0, 0, 0);
        smp();
        chk("perf_conflict", pcf, 5);
        chk("perf_sum", 32'(pg0) + 32'(pg1), 5);
        chk("perf_g0", pg0, 3);
        nxt();
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
- Controller that shares one single-port 512x16 SRAM macro between two requesters (port 0, port 1), one access per cycle.
- The macro has active-low CEB/WEB, samples on the rising clock edge and returns read data on Q one cycle after sampling.
- The block arbitrates the two requesters, registers the macro control and address/data pins, captures Q, and returns read data per port through small response FIFOs.
- It sits between memory-core address generators and the SRAM macro instance.

Parameters:
- DATA_WIDTH, 16, SRAM word width.
- ADDR_WIDTH, 9, SRAM address width.
- RSP_DEPTH, 3, per-port response FIFO depth and read credit count; 3 gives full read throughput.
- PRIORITY_MODE, 0, arbitration policy: 0 = round robin, 1 = fixed priority with port 0 winning.
- TSEL, 2'b00, value driven on sram_rtsel and sram_wtsel.

Ports:
- clk  in  1  clock for all state and the macro.
- reset  in  1  asynchronous, active-high reset.
- reqN_valid  in  1  request from port N (N=0,1).
- reqN_ready  out  1  request from port N accepted this cycle.
- reqN_wen  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_WIDTH  word address.
- reqN_wdata  in  DATA_WIDTH  write data.
- rspN_valid  out  1  read response available for port N.
- rspN_data  out  DATA_WIDTH  read data for port N.
- rspN_ready  in  1  port N consumes its response.
- sram_ceb  out  1  macro chip enable, active low.
- sram_web  out  1  macro write enable, active low.
- sram_a  out  ADDR_WIDTH  macro address.
- sram_d  out  DATA_WIDTH  macro write data.
- sram_q  in  DATA_WIDTH  macro read data.
- sram_rtsel, sram_wtsel  out  2  tied to TSEL.

Behaviour:

Reset values:
- sram_ceb=1, sram_web=1, sram_a=0, sram_d=0.
- rsp0_valid=rsp1_valid=0; both FIFOs empty.
- Read pipeline cleared; credits = RSP_DEPTH per port.
- Round-robin pointer set so port 0 wins the first tie.

Eligibility:
- Port N is eligible when reqN_valid=1 and either reqN_wen=1, or reqN_wen=0 and credits_N>0.
- Writes are posted: they produce no response and consume no credit.

Grant:
- At most one grant per cycle.
- PRIORITY_MODE=0: when both ports are eligible, grant the port not granted last; the pointer updates only on a grant.
- PRIORITY_MODE=1: port 0 always wins a tie.
- reqN_ready = granted_N. It is combinational from both valid inputs and the credit state. Requesters must not make valid depend on ready.

Issue:
- Acceptance at edge E0 registers the following, effective in the cycle after E0:
  - sram_ceb=0
  - sram_web=~wen
  - sram_a=addr
  - sram_d=wdata (writes only; sram_d holds for reads)
- The macro samples at E1.
- With no grant: sram_ceb=1, sram_web=1, and sram_a/sram_d hold their values (no toggling).

Read return:
- A 2-stage tag pipeline (valid + port id) follows each read.
- sram_q is written into the FIFO of the tagged port at E2.
- rspN_valid is high after E2, giving a fixed 2-cycle latency from the acceptance edge to rsp_valid.

Credits:
- Decrement on read acceptance; increment when a response is popped (rspN_valid & rspN_ready).
- Simultaneous accept and pop leaves the count unchanged.
- Credits can never exceed RSP_DEPTH, so the FIFO never overflows.
- A port with 0 credits is not eligible. The other port still proceeds (no head-of-line blocking across ports).

Ordering:
- Macro accesses occur in grant order. A read granted after a write to the same address returns the new data.
- Responses per port are returned in request order.

FIFO:
- Pop and push in the same cycle on a full FIFO is legal.
- rspN_data is valid only while rspN_valid=1 and holds until popped.

Reset mid-operation:
- In-flight reads are discarded.
- Any access registered but not yet sampled is cancelled (sram_ceb forced to 1 asynchronously).

Optional Feature:
- Macro: SRAM_ARB_PERF_EN.
- Defined: adds outputs perf_grant0, perf_grant1 and perf_conflict, each 16 bits.
  - perf_grant0/perf_grant1 count grants per port.
  - perf_conflict counts cycles where both ports are valid and one is stalled.
  - All counters saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Port 0 writes 0xA5A5 to address 0x010, then reads 0x010 -> sram_ceb=0/sram_web=0 one cycle after acceptance, then sram_web=1; rsp0_valid asserts 2 cycles after read acceptance with rsp0_data=0xA5A5.
- Both ports issue continuous reads, PRIORITY_MODE=0, both rsp_ready=1 -> grants alternate 0,1,0,1 starting with port 0; one sram access every cycle; no stalls.
- Port 1 reads 4 addresses with rsp1_ready=0 -> exactly 3 accepted; req1_ready=0 afterwards while port 0 reads still granted; raising rsp1_ready drains in order and the 4th read is then accepted.
- Same cycle: port 0 writes 0x1234 to address 0x1FF and port 1 reads 0x1FF, PRIORITY_MODE=1 -> write issued first and read returns 0x1234; with port order reversed (PRIORITY_MODE=0, pointer favoring port 1) the read returns the old value.
- Assert reset one cycle after a read acceptance -> sram_ceb=1 immediately, no rsp_valid ever appears, credits return to 3, and the next read completes normally.
- With SRAM_ARB_PERF_EN defined: 5 contended cycles -> perf_conflict=5 and perf_grant0+perf_grant1 equals the total grants.
